// File: rtl/async_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : async_fifo_pkg
//  Description : Shared constants and types for async_fifo and its read-side
//                drain engine (fifo_rd_stream / rd_skid_buf).
//  Revision    : 1.0 - initial release
// ============================================================================
package async_fifo_pkg;

  // Default geometry shared with async_fifo
  localparam int DSIZE_DEF    = 8;
  localparam int ASIZE_DEF    = 4;

  // Depth of the read-side output buffer
  localparam int RD_BUF_DEPTH = 2;

  // Output buffer occupancy: 0, 1 or 2 words
  typedef logic [1:0] rd_occ_t;

  localparam rd_occ_t OCC_EMPTY = 2'd0;
  localparam rd_occ_t OCC_ONE   = 2'd1;
  localparam rd_occ_t OCC_FULL  = 2'(RD_BUF_DEPTH);

endpackage : async_fifo_pkg
`default_nettype wire

// File: rtl/rd_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : rd_skid_buf
//  Description : Two-slot output buffer. slot0 is the head and drives the
//                stream data; slot1 holds the second word. Occupancy, valid
//                and data are all registered. Flush empties the buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module rd_skid_buf
  import async_fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [DSIZE-1:0] push_data_i,
  input  logic             ready_i,
  input  logic             flush_i,
  output rd_occ_t          cnt_o,
  output logic             valid_o,
  output logic [DSIZE-1:0] data_o
);

  rd_occ_t          cnt_q,   cnt_d;
  logic [DSIZE-1:0] slot0_q, slot0_d;
  logic [DSIZE-1:0] slot1_q, slot1_d;
  logic             valid_q, valid_d;
  logic             w_pop;

  // A word leaves only when presented and accepted; flush overrides acceptance
  assign w_pop = valid_q & ready_i & ~flush_i;

  // Next-state for occupancy and slots
  always_comb begin
    cnt_d   = cnt_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    if (flush_i) begin
      // Buffered words are discarded; slot contents are don't-care once empty
      cnt_d = OCC_EMPTY;
    end else begin
      case ({push_i, w_pop})
        2'b10: begin
          if (cnt_q == OCC_EMPTY) begin
            slot0_d = push_data_i;
          end else if (cnt_q == OCC_ONE) begin
            slot1_d = push_data_i;
          end
          if (cnt_q != OCC_FULL) begin
            cnt_d = cnt_q + 2'd1;
          end
        end
        2'b01: begin
          slot0_d = slot1_q;
          cnt_d   = cnt_q - 2'd1;
        end
        2'b11: begin
          // Push gating keeps this at cnt=1; the full case shifts safely anyway
          if (cnt_q == OCC_FULL) begin
            slot0_d = slot1_q;
            slot1_d = push_data_i;
          end else begin
            slot0_d = push_data_i;
          end
        end
        default: begin
        end
      endcase
    end
    valid_d = (cnt_d != OCC_EMPTY);
  end

  // Buffer state registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= OCC_EMPTY;
      slot0_q <= '0;
      slot1_q <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      valid_q <= valid_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign valid_o = valid_q;
  assign data_o  = slot0_q;

endmodule : rd_skid_buf
`default_nettype wire

// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_stream
//  Description : Read-domain drain engine for async_fifo. Pops the FIFO read
//                port into a two-slot buffer and presents a valid/ready
//                stream. m_ready never reaches rinc combinationally; rinc
//                depends only on registered occupancy and drain_en/flush/
//                rempty. Also provides a wrapping pop counter and idle flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_stream
  import async_fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int CNT_W = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data,
  input  logic             drain_en,
  input  logic             flush,
  output logic [CNT_W-1:0] pop_count,
  output logic             idle
);

  rd_occ_t          w_cnt;
  logic             w_rinc;
  logic [CNT_W-1:0] pop_count_q, pop_count_d;

  // Pop whenever allowed, not flushing, data present and a slot is free.
  // Reset gating keeps the strobe low while the buffer is held cleared.
  assign w_rinc = rrst_n & drain_en & ~flush & ~rempty & (w_cnt != OCC_FULL);

  rd_skid_buf #(
    .DSIZE (DSIZE)
  ) u_buf (
    .clk_i       (rclk),
    .rst_ni      (rrst_n),
    .push_i      (w_rinc),
    .push_data_i (rdata),
    .ready_i     (m_ready),
    .flush_i     (flush),
    .cnt_o       (w_cnt),
    .valid_o     (m_valid),
    .data_o      (m_data)
  );

  // Pop counter next value: count every FIFO pop, wrapping naturally
  always_comb begin
    pop_count_d = pop_count_q;
    if (w_rinc) begin
      pop_count_d = pop_count_q + CNT_W'(1);
    end
  end

  // Pop counter register; only reset clears it, flush leaves it alone
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      pop_count_q <= '0;
    end else begin
      pop_count_q <= pop_count_d;
    end
  end

  assign rinc      = w_rinc;
  assign pop_count = pop_count_q;
  assign idle      = (w_cnt == OCC_EMPTY) & rempty;

endmodule : fifo_rd_stream
`default_nettype wire
